// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate exhaustive-test flow: expected-function
// selector codes and checker FSM state encodings.
package gate_test_pkg;

  localparam logic [1:0] FUNC_OR  = 2'd0;
  localparam logic [1:0] FUNC_AND = 2'd1;
  localparam logic [1:0] FUNC_XOR = 2'd2;
  localparam logic [1:0] FUNC_NOR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference gate: reduction OR/AND/XOR/NOR of the applied vector.
// Shared with stimulus-side blocks that need the golden response.
module gate_ref_model
  import gate_test_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [1:0]      i_func,
  input  logic [N_IN-1:0] i_vec,
  output logic            o_exp
);

  // Expected gate response for the selected function
  always_comb begin
    o_exp = 1'b0;
    case (i_func)
      FUNC_OR:  o_exp = |i_vec;
      FUNC_AND: o_exp = &i_vec;
      FUNC_XOR: o_exp = ^i_vec;
      FUNC_NOR: o_exp = ~|i_vec;
      default:  o_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_resp_checker.sv
// Response checker for exhaustive gate testing: compares each (vec, dut_out) pair
// against the reference gate, counts errors/accepts and tracks vector coverage.
module gate_resp_checker
  import gate_test_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_func_sel,
  input  logic             i_vec_valid,
  output logic             o_vec_ready,
  input  logic [N_IN-1:0]  i_vec,
  input  logic             i_dut_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_acc_cnt,
  output logic             o_first_err_vld,
  output logic [N_IN-1:0]  o_first_err_vec
);

  localparam int               COV_W    = 1 << N_IN;
  localparam logic [COV_W-1:0] COV_ONE  = {{(COV_W-1){1'b0}}, 1'b1};
  localparam logic [COV_W-1:0] COV_ALL  = {COV_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_func;
  logic [COV_W-1:0] r_cov;
  logic [COV_W-1:0] w_cov_nxt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_acc_cnt;
  logic             r_fe_vld;
  logic [N_IN-1:0]  r_fe_vec;
  logic             w_exp;
  logic             w_xfer;
  logic             w_mismatch;
  logic             w_cov_full;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .i_func (r_func),
    .i_vec  (i_vec),
    .o_exp  (w_exp)
  );

  assign o_busy      = (r_state == ST_RUN);
  assign o_done      = (r_state == ST_DONE);
  // A start in RUN restarts the run, so the pair offered alongside it is refused
  assign o_vec_ready = o_busy && !i_start;
  assign w_xfer      = i_vec_valid && o_vec_ready;
  assign w_mismatch  = w_xfer && (i_dut_out != w_exp);
  assign w_cov_nxt   = r_cov | (COV_ONE << i_vec);
  assign w_cov_full  = (w_cov_nxt == COV_ALL);

  assign o_pass          = o_done && (r_err_cnt == CNT_ZERO);
  assign o_err_cnt       = r_err_cnt;
  assign o_acc_cnt       = r_acc_cnt;
  assign o_first_err_vld = r_fe_vld;
  assign o_first_err_vec = r_fe_vec;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_RUN;
        else         w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (i_start)                   w_state_nxt = ST_RUN;
        else if (w_xfer && w_cov_full) w_state_nxt = ST_DONE;
        else                           w_state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (i_start) w_state_nxt = ST_RUN;
        else         w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Results, coverage and first-error capture; start clears from any state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_func    <= FUNC_OR;
      r_cov     <= {COV_W{1'b0}};
      r_err_cnt <= CNT_ZERO;
      r_acc_cnt <= CNT_ZERO;
      r_fe_vld  <= 1'b0;
      r_fe_vec  <= {N_IN{1'b0}};
    end else if (i_start) begin
      r_func    <= i_func_sel;
      r_cov     <= {COV_W{1'b0}};
      r_err_cnt <= CNT_ZERO;
      r_acc_cnt <= CNT_ZERO;
      r_fe_vld  <= 1'b0;
      r_fe_vec  <= {N_IN{1'b0}};
    end else if (w_xfer) begin
      r_cov <= w_cov_nxt;
      if (r_acc_cnt != CNT_MAX) r_acc_cnt <= r_acc_cnt + CNT_ONE;
      if (w_mismatch) begin
        if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + CNT_ONE;
        if (!r_fe_vld) begin
          r_fe_vld <= 1'b1;
          r_fe_vec <= i_vec;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_resp_checker.sv
// Self-checking bench: two checkers (CNT_W=8 and CNT_W=2) share one directed stimulus
// stream and are compared every cycle against a behavioural model of the run.
module tb_gate_resp_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] func_sel = 2'd0;
  logic       vec_valid = 1'b0;
  logic [2:0] vec = 3'd0;
  logic       dut_out = 1'b0;

  logic       rdy_a, busy_a, done_a, pass_a, fev_a;
  logic [7:0] err_a, acc_a;
  logic [2:0] fvec_a;
  logic       rdy_b, busy_b, done_b, pass_b, fev_b;
  logic [1:0] err_b, acc_b;
  logic [2:0] fvec_b;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  gate_resp_checker #(.N_IN(3), .CNT_W(8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_func_sel(func_sel),
    .i_vec_valid(vec_valid), .o_vec_ready(rdy_a), .i_vec(vec), .i_dut_out(dut_out),
    .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a), .o_err_cnt(err_a),
    .o_acc_cnt(acc_a), .o_first_err_vld(fev_a), .o_first_err_vec(fvec_a)
  );

  gate_resp_checker #(.N_IN(3), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_func_sel(func_sel),
    .i_vec_valid(vec_valid), .o_vec_ready(rdy_b), .i_vec(vec), .i_dut_out(dut_out),
    .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b), .o_err_cnt(err_b),
    .o_acc_cnt(acc_b), .o_first_err_vld(fev_b), .o_first_err_vec(fvec_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Golden gate response from the count of ones in the vector
  function automatic bit gate_f(input int f, input int v);
    int ones;
    ones = $countones(v[2:0]);
    case (f)
      0:       return ones > 0;
      1:       return ones == 3;
      2:       return (ones % 2) == 1;
      default: return ones == 0;
    endcase
  endfunction

  // Behavioural model: 0 idle, 1 running, 2 finished
  int m_mode = 0;
  int m_acc = 0;
  int m_err = 0;
  int m_func = 0;
  int m_nseen = 0;
  bit m_seen [8];
  bit m_fe_vld = 1'b0;
  int m_fe_vec = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_acc <= 0; m_err <= 0; m_func <= 0; m_nseen <= 0;
      m_fe_vld <= 1'b0; m_fe_vec <= 0;
      for (int i = 0; i < 8; i++) m_seen[i] <= 1'b0;
    end else if (start) begin
      m_mode <= 1; m_acc <= 0; m_err <= 0; m_func <= int'(func_sel); m_nseen <= 0;
      m_fe_vld <= 1'b0; m_fe_vec <= 0;
      for (int i = 0; i < 8; i++) m_seen[i] <= 1'b0;
    end else if (m_mode == 1 && vec_valid) begin
      m_acc <= m_acc + 1;
      m_seen[vec] <= 1'b1;
      if (!m_seen[vec]) m_nseen <= m_nseen + 1;
      if (m_nseen + (m_seen[vec] ? 0 : 1) == 8) m_mode <= 2;
      if (dut_out != gate_f(m_func, int'(vec))) begin
        m_err <= m_err + 1;
        if (!m_fe_vld) begin
          m_fe_vld <= 1'b1;
          m_fe_vec <= int'(vec);
        end
      end
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Every-cycle comparison of both checkers against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_a", int'(busy_a), int'(m_mode == 1));
      chk("done_a", int'(done_a), int'(m_mode == 2));
      chk("ready_a", int'(rdy_a), int'(m_mode == 1 && !start));
      chk("pass_a", int'(pass_a), int'(m_mode == 2 && m_err == 0));
      chk("err_a", int'(err_a), sat(m_err, 255));
      chk("acc_a", int'(acc_a), sat(m_acc, 255));
      chk("fev_a", int'(fev_a), int'(m_fe_vld));
      chk("fvec_a", int'(fvec_a), m_fe_vec);
      chk("ready_b", int'(rdy_b), int'(m_mode == 1 && !start));
      chk("done_b", int'(done_b), int'(m_mode == 2));
      chk("pass_b", int'(pass_b), int'(m_mode == 2 && m_err == 0));
      chk("err_b", int'(err_b), sat(m_err, 3));
      chk("acc_b", int'(acc_b), sat(m_acc, 3));
      chk("fvec_b", int'(fvec_b), m_fe_vec);
    end
  end

  task automatic do_start(input logic [1:0] f);
    start = 1'b1; func_sel = f;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int v, input bit d);
    vec_valid = 1'b1; vec = v[2:0]; dut_out = d;
    @(posedge clk); #1;
    vec_valid = 1'b0;
  endtask

  task automatic restart_with_pair(input logic [1:0] f, input int v, input bit d);
    start = 1'b1; func_sel = f; vec_valid = 1'b1; vec = v[2:0]; dut_out = d;
    @(posedge clk); #1;
    start = 1'b0; vec_valid = 1'b0;
  endtask

  initial begin
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_ready", int'(rdy_a), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: OR, all vectors in order, all correct
    do_start(2'd0);
    for (int v = 0; v < 8; v++) send(v, v != 0);
    chk("t1_done", int'(done_a), 1);
    chk("t1_pass", int'(pass_a), 1);
    chk("t1_acc", int'(acc_a), 8);
    chk("t1_err", int'(err_a), 0);
    chk("t1_ready", int'(rdy_a), 0);

    // 2: AND, vector 5 answered wrongly
    do_start(2'd1);
    for (int v = 0; v < 8; v++) send(v, (v == 5) || (v == 7));
    chk("t2_err", int'(err_a), 1);
    chk("t2_fvec", int'(fvec_a), 5);
    chk("t2_fev", int'(fev_a), 1);
    chk("t2_pass", int'(pass_a), 0);

    // 3: XOR with a duplicate first vector
    do_start(2'd2);
    send(0, 1'b0);
    for (int v = 0; v < 7; v++) send(v, ($countones(v) % 2) == 1);
    chk("t3_notdone", int'(done_a), 0);
    send(7, 1'b1);
    chk("t3_done", int'(done_a), 1);
    chk("t3_acc", int'(acc_a), 9);
    chk("t3_pass", int'(pass_a), 1);

    // 4: NOR, every output inverted; narrow counters saturate
    do_start(2'd3);
    for (int v = 0; v < 8; v++) send(v, v != 0);
    chk("t4_err_b", int'(err_b), 3);
    chk("t4_acc_b", int'(acc_b), 3);
    chk("t4_err_a", int'(err_a), 8);
    chk("t4_fvec", int'(fvec_b), 0);
    chk("t4_done_b", int'(done_b), 1);

    // 5: reset mid-run, then valid ignored while idle
    do_start(2'd0);
    for (int v = 0; v < 4; v++) send(v, v != 0);
    rst_n = 1'b0; vec_valid = 1'b1;
    #1;
    chk("t5_busy", int'(busy_a), 0);
    chk("t5_acc", int'(acc_a), 0);
    chk("t5_ready", int'(rdy_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t5_idle_ready", int'(rdy_a), 0);
      chk("t5_idle_acc", int'(acc_a), 0);
    end
    vec_valid = 1'b0;

    // 6: restart from DONE with XOR, then a mid-run restart dropping its pair
    do_start(2'd0);
    for (int v = 0; v < 8; v++) send(v, v != 0);
    chk("t6_done_or", int'(done_a), 1);
    do_start(2'd2);
    chk("t6_busy", int'(busy_a), 1);
    chk("t6_acc0", int'(acc_a), 0);
    func_sel = 2'd1;
    send(0, 1'b0); send(1, 1'b1); send(2, 1'b1);
    restart_with_pair(2'd2, 3, 1'b1);
    chk("t6_drop_acc", int'(acc_a), 0);
    chk("t6_drop_err", int'(err_a), 0);
    func_sel = 2'd1;
    for (int v = 0; v < 8; v++) send(v, (v == 6) ? 1'b1 : (($countones(v) % 2) == 1));
    chk("t6_done", int'(done_a), 1);
    chk("t6_err", int'(err_a), 1);
    chk("t6_fvec", int'(fvec_a), 6);
    chk("t6_acc", int'(acc_a), 8);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_hold_err", int'(err_a), 1);

    @(negedge clk);
    #1 chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
